// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: instruction/data requester and physical-memory bus bundle
interface mem_arbiter_if;
    logic        i_mem_read;
    logic [15:0] i_mem_address;
    logic [15:0] i_mem_rdata;
    logic        i_mem_resp;
    logic        d_mem_read;
    logic        d_mem_write;
    logic [1:0]  d_mem_byte_enable;
    logic [15:0] d_mem_address;
    logic [15:0] d_mem_wdata;
    logic [15:0] d_mem_rdata;
    logic        d_mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic [1:0]  pmem_byte_enable;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;
    modport slave (
        input  i_mem_read, i_mem_address, d_mem_read, d_mem_write, d_mem_byte_enable,
               d_mem_address, d_mem_wdata, pmem_rdata, pmem_resp,
        output i_mem_rdata, i_mem_resp, d_mem_rdata, d_mem_resp, pmem_read, pmem_write,
               pmem_byte_enable, pmem_address, pmem_wdata
    );
    modport master (
        output i_mem_read, i_mem_address, d_mem_read, d_mem_write, d_mem_byte_enable,
               d_mem_address, d_mem_wdata, pmem_rdata, pmem_resp,
        input  i_mem_rdata, i_mem_resp, d_mem_rdata, d_mem_resp, pmem_read, pmem_write,
               pmem_byte_enable, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester (I/D) arbiter onto one physical memory port
module mem_arbiter #(
    parameter bit FAIR = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    state_t      state_q, state_d;
    logic        last_d_q, last_d_d;
    logic        wr_q, wr_d;
    logic [1:0]  be_q, be_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        i_req, d_req, grant_d, busy;
    assign i_req   = bus.i_mem_read;
    assign d_req   = bus.d_mem_read | bus.d_mem_write;
    // on conflict the data side wins unless fairness says I is owed a turn
    assign grant_d = d_req & (!i_req | !FAIR | !last_d_q);
    assign busy    = state_q != IDLE;
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        wr_d     = wr_q;
        be_d     = be_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        if (!busy && (i_req || d_req)) begin
            state_d  = grant_d ? BUSY_D : BUSY_I;
            last_d_d = grant_d;
            wr_d     = grant_d & bus.d_mem_write;
            be_d     = grant_d ? bus.d_mem_byte_enable : 2'b11;
            addr_d   = grant_d ? bus.d_mem_address : bus.i_mem_address;
            wdata_d  = grant_d ? bus.d_mem_wdata : 16'h0000;
        end else if (busy && bus.pmem_resp) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            wr_q     <= 1'b0;
            be_q     <= 2'b00;
            addr_q   <= 16'h0000;
            wdata_q  <= 16'h0000;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            wr_q     <= wr_d;
            be_q     <= be_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end
    assign bus.pmem_read        = busy & !wr_q;
    assign bus.pmem_write       = busy & wr_q;
    assign bus.pmem_byte_enable = be_q;
    assign bus.pmem_address     = addr_q;
    assign bus.pmem_wdata       = wdata_q;
    assign bus.i_mem_resp       = (state_q == BUSY_I) & bus.pmem_resp;
    assign bus.d_mem_resp       = (state_q == BUSY_D) & bus.pmem_resp;
    assign bus.i_mem_rdata      = bus.pmem_rdata;
    assign bus.d_mem_rdata      = bus.pmem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: vector table plus scoreboard checks for both arbitration modes
module tb_mem_arbiter;
    typedef struct {
        logic        ir, dr, dw;
        logic [1:0]  be;
        logic [15:0] ia, da, wd;
        int          dly;
        logic [15:0] rd;
        logic        es, ew;
        logic [15:0] ea;
        logic [1:0]  ebe;
        logic [15:0] ewd;
    } vec_t;
    typedef struct {
        logic        es, ew;
        logic [1:0]  ebe;
        logic [15:0] ea, ewd, rd;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];
    vec_t v[10];
    mem_arbiter_if f();
    mem_arbiter_if p();
    mem_arbiter #(.FAIR(1'b1)) u_fair (.clk(clk), .rst_n(rst_n), .bus(f.slave));
    mem_arbiter #(.FAIR(1'b0)) u_prio (.clk(clk), .rst_n(rst_n), .bus(p.slave));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask
    always @(negedge clk) begin
        if (f.pmem_resp && (f.pmem_read || f.pmem_write)) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_txn", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_op", {f.pmem_read, f.pmem_write}, e.ew ? 2'b01 : 2'b10);
                chk("sb_addr", f.pmem_address, e.ea);
                chk("sb_be", f.pmem_byte_enable, e.ebe);
                chk("sb_wdata", f.pmem_wdata, e.ewd);
                chk("sb_resp", {f.i_mem_resp, f.d_mem_resp}, e.es ? 2'b01 : 2'b10);
                chk("sb_rdata", e.es ? f.d_mem_rdata : f.i_mem_rdata, e.rd);
            end
        end
    end
    task automatic clear_f();
        f.i_mem_read = 0; f.d_mem_read = 0; f.d_mem_write = 0;
        f.i_mem_address = 0; f.d_mem_address = 0; f.d_mem_byte_enable = 0; f.d_mem_wdata = 0;
    endtask
    task automatic txn(input vec_t t);
        @(posedge clk); #1;
        f.i_mem_read = t.ir; f.d_mem_read = t.dr; f.d_mem_write = t.dw;
        f.d_mem_byte_enable = t.be; f.i_mem_address = t.ia; f.d_mem_address = t.da; f.d_mem_wdata = t.wd;
        sb.push_back('{t.es, t.ew, t.ebe, t.ea, t.ewd, t.rd});
        @(negedge clk);
        chk("idle_no_op", {f.pmem_read, f.pmem_write}, 0);
        @(posedge clk); #1;
        clear_f();
        f.d_mem_address = 16'hFFFF;
        @(negedge clk);
        chk("grant_op", {f.pmem_read, f.pmem_write}, t.ew ? 2'b01 : 2'b10);
        chk("grant_addr", f.pmem_address, t.ea);
        chk("grant_be", f.pmem_byte_enable, t.ebe);
        chk("busy_no_resp", {f.i_mem_resp, f.d_mem_resp}, 0);
        repeat (t.dly) @(posedge clk);
        #1;
        f.pmem_resp = 1; f.pmem_rdata = t.rd;
        @(posedge clk); #1;
        f.pmem_resp = 0; f.pmem_rdata = 0;
        @(negedge clk);
        chk("back_idle", {f.pmem_read, f.pmem_write, f.i_mem_resp, f.d_mem_resp}, 0);
    endtask
    initial begin
        clear_f();
        f.pmem_resp = 0; f.pmem_rdata = 0;
        p.i_mem_read = 0; p.d_mem_read = 0; p.d_mem_write = 0; p.i_mem_address = 0;
        p.d_mem_address = 0; p.d_mem_byte_enable = 0; p.d_mem_wdata = 0;
        p.pmem_resp = 0; p.pmem_rdata = 0;
        v[0] = '{1, 1, 0, 2'b11, 16'h0010, 16'h0020, 16'h0000, 3, 16'h1234, 0, 0, 16'h0010, 2'b11, 16'h0000};
        v[1] = '{0, 0, 1, 2'b01, 16'h0000, 16'h0101, 16'h00AB, 1, 16'h0000, 1, 1, 16'h0101, 2'b01, 16'h00AB};
        v[2] = '{1, 0, 0, 2'b00, 16'h0010, 16'h0000, 16'h0000, 3, 16'h1234, 0, 0, 16'h0010, 2'b11, 16'h0000};
        v[3] = '{0, 1, 0, 2'b11, 16'h0000, 16'h2000, 16'h5555, 2, 16'hCAFE, 1, 0, 16'h2000, 2'b11, 16'h5555};
        v[4] = '{1, 1, 0, 2'b11, 16'h0300, 16'h0400, 16'h0000, 1, 16'h0303, 0, 0, 16'h0300, 2'b11, 16'h0000};
        v[5] = '{1, 0, 1, 2'b10, 16'h0301, 16'h0401, 16'hBEEF, 2, 16'h0000, 1, 1, 16'h0401, 2'b10, 16'hBEEF};
        v[6] = '{0, 1, 1, 2'b11, 16'h0000, 16'h0500, 16'h1111, 1, 16'h0000, 1, 1, 16'h0500, 2'b11, 16'h1111};
        v[7] = '{1, 1, 1, 2'b01, 16'h0600, 16'h0700, 16'h2222, 1, 16'h0606, 0, 0, 16'h0600, 2'b11, 16'h0000};
        v[8] = '{1, 1, 0, 2'b11, 16'h0601, 16'h0701, 16'h3333, 2, 16'h7777, 1, 0, 16'h0701, 2'b11, 16'h3333};
        v[9] = '{1, 1, 0, 2'b11, 16'h0D00, 16'h0E00, 16'h0000, 1, 16'h0DDD, 0, 0, 16'h0D00, 2'b11, 16'h0000};
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_ops", {f.pmem_read, f.pmem_write, f.i_mem_resp, f.d_mem_resp}, 0);
        chk("rst_latch", {f.pmem_address, f.pmem_wdata, 14'h0, f.pmem_byte_enable}, 0);
        chk("rst_ops_prio", {p.pmem_read, p.pmem_write}, 0);
        for (int i = 0; i < 9; i++) txn(v[i]);
        @(posedge clk); #1;
        f.i_mem_read = 1; f.i_mem_address = 16'hA000;
        f.d_mem_read = 1; f.d_mem_address = 16'hB000; f.d_mem_byte_enable = 2'b11; f.d_mem_wdata = 16'h4444;
        for (int k = 0; k < 4; k++) begin
            logic s;
            s = k[0];
            sb.push_back('{s, 1'b0, 2'b11, s ? 16'hB000 : 16'hA000, s ? 16'h4444 : 16'h0000, 16'h9000 + 16'(k)});
            @(negedge clk);
            chk("rr_idle_gap", {f.pmem_read, f.pmem_write}, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("rr_grant_addr", f.pmem_address, s ? 16'hB000 : 16'hA000);
            @(posedge clk); #1;
            f.pmem_resp = 1; f.pmem_rdata = 16'h9000 + 16'(k);
            @(posedge clk); #1;
            f.pmem_resp = 0;
        end
        clear_f();
        f.d_mem_read = 1; f.d_mem_address = 16'h0C00; f.d_mem_byte_enable = 2'b11;
        @(posedge clk); #1;
        f.d_mem_read = 0;
        @(negedge clk);
        chk("abort_busy", f.pmem_read, 1);
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1; f.pmem_resp = 1;
        @(negedge clk);
        chk("abort_ops", {f.pmem_read, f.pmem_write, f.i_mem_resp, f.d_mem_resp}, 0);
        chk("abort_addr", f.pmem_address, 0);
        @(posedge clk); #1;
        f.pmem_resp = 0;
        @(negedge clk);
        chk("abort_stay_idle", {f.pmem_read, f.pmem_write}, 0);
        txn(v[9]);
        @(posedge clk); #1;
        p.i_mem_read = 1; p.i_mem_address = 16'h1000;
        p.d_mem_write = 1; p.d_mem_address = 16'h2000; p.d_mem_byte_enable = 2'b10; p.d_mem_wdata = 16'h5A5A;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("prio_idle_gap", {p.pmem_read, p.pmem_write}, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("prio_grant", {p.pmem_read, p.pmem_write, p.pmem_address}, {2'b01, 16'h2000});
            chk("prio_wdata", {p.pmem_byte_enable, p.pmem_wdata}, {2'b10, 16'h5A5A});
            @(posedge clk); #1;
            p.pmem_resp = 1; p.pmem_rdata = 16'h0BAD + 16'(k);
            @(negedge clk);
            chk("prio_resp", {p.i_mem_resp, p.d_mem_resp}, 2'b01);
            chk("prio_rdata", p.d_mem_rdata, 16'h0BAD + 16'(k));
            @(posedge clk); #1;
            p.pmem_resp = 0;
        end
        p.i_mem_read = 0; p.d_mem_write = 0;
        repeat (2) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: FAIR, default 1, 1 = round-robin on conflict, 0 = fixed data-side priority.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 i_mem_read  in  1  instruction-side read request, held until i_mem_resp.
REQ-005 i_mem_address  in  16  instruction-side word address.
REQ-006 i_mem_rdata  out  16  instruction-side read data.
REQ-007 i_mem_resp  out  1  instruction-side completion strobe.
REQ-008 d_mem_read  in  1  data-side read request, held until d_mem_resp.
REQ-009 d_mem_write  in  1  data-side write request, held until d_mem_resp.
REQ-010 d_mem_byte_enable  in  2  data-side byte mask (lc3b_mem_wmask).
REQ-011 d_mem_address  in  16  data-side address.
REQ-012 d_mem_wdata  in  16  data-side write data.
REQ-013 d_mem_rdata  out  16  data-side read data.
REQ-014 d_mem_resp  out  1  data-side completion strobe.
REQ-015 pmem_read, pmem_write  out  1 each  physical memory request.
REQ-016 pmem_byte_enable  out  2;  pmem_address  out  16;  pmem_wdata  out  16.
REQ-017 pmem_rdata  in  16;  pmem_resp  in  1  physical memory read data and completion.

Function
REQ-018 States: IDLE, BUSY_I, BUSY_D; state register plus last_grant flag (I/D) plus latch registers for op, byte mask, address, wdata.
REQ-019 IDLE: pmem_read = pmem_write = 0; pmem_resp ignored; i_mem_resp = d_mem_resp = 0.
REQ-020 IDLE, only i_mem_read high: next state BUSY_I; latch read, address = i_mem_address, byte mask = 2'b11, wdata = 0.
REQ-021 IDLE, only d_mem_read or d_mem_write high: next state BUSY_D; latch op, d_mem_address, d_mem_byte_enable, d_mem_wdata.
REQ-022 IDLE, both sides requesting: FAIR=1 grants the side opposite last_grant; FAIR=0 always grants D.
REQ-023 last_grant updates to the granted side on every IDLE->BUSY transition.
REQ-024 d_mem_read and d_mem_write both high: latch as write; read suppressed.
REQ-025 BUSY_x: pmem_* outputs driven solely from the latch registers; requester inputs ignored until return to IDLE.
REQ-026 Latency: request sampled in IDLE at cycle N gives pmem_read/pmem_write high from cycle N+1.
REQ-027 BUSY_x with pmem_resp high in cycle M: x_mem_resp = 1 combinationally in cycle M; next state IDLE; other side's resp stays 0.
REQ-028 BUSY_x with pmem_resp low: remain in BUSY_x, outputs unchanged.
REQ-029 i_mem_rdata and d_mem_rdata continuously equal pmem_rdata; only the resp strobe qualifies validity.
REQ-030 Exactly one idle cycle separates consecutive grants; there is no back-to-back BUSY->BUSY transition.
REQ-031 Requester dropping its request mid-grant has no effect; the transaction completes and resp is still pulsed.
REQ-032 pmem_read and pmem_write are never both high.
REQ-033 pmem_read/pmem_write are never high in IDLE.

Reset
REQ-034 rst_n low at a rising edge: state = IDLE, last_grant = D, latch registers = 0, regardless of current state.
REQ-035 Reset during BUSY_x aborts the transaction: pmem_read/pmem_write are 0 from the next cycle, no resp is issued, and a late pmem_resp is ignored.
REQ-036 First conflict after reset with FAIR=1 grants I.

Verification
REQ-037 I-only read: i_mem_read=1, addr 0x0010; memory responds 3 cycles later with 0x1234 -> pmem_read is high from N+1 with pmem_address 0x0010 and byte mask 11; i_mem_resp pulses one cycle with i_mem_rdata 0x1234; d_mem_resp stays 0.
REQ-038 D byte write: d_mem_write=1, addr 0x0101, mask 01, wdata 0x00AB -> pmem_write=1 with the same values, pmem_read=0; d_mem_resp pulses one cycle.
REQ-039 Conflict, FAIR=1: after reset, I and D requests are held continuously -> grant order I, D, I, D, with exactly one IDLE cycle between grants.
REQ-040 Conflict, FAIR=0: I and D requests are held continuously -> D granted every time and I starves; D re-requesting immediately after d_mem_resp is regranted after one IDLE cycle.
REQ-041 Requester drop: d_mem_read is deasserted and d_mem_address changed in the cycle after grant -> pmem_address keeps the latched value and d_mem_resp still pulses on pmem_resp.
REQ-042 Reset mid-op: rst_n is pulled low during BUSY_D, then pmem_resp pulses -> pmem_read=0 next cycle, no d_mem_resp, state IDLE.
